// File: rtl/ram_output_ctrl_if.sv
// Bundle of the MAC write, host read, classify and external RAM signals
// of the output-RAM controller. The controller uses the slave view; the
// surrounding system (MAC, host, RAM) uses the master view.
interface ram_output_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  // MAC write request
  logic                  mac_valid;
  logic [ADDR_WIDTH-1:0] mac_addr;
  logic [DATA_WIDTH-1:0] mac_data;
  logic                  mac_ready;
  // host single-word read
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  // classify (argmax)
  logic                  cls_start;
  logic                  cls_busy;
  logic                  cls_done;
  logic [ADDR_WIDTH-1:0] cls_idx;
  logic [DATA_WIDTH-1:0] cls_max;
  // external RAM drive and read data
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  mac_valid, mac_addr, mac_data, rd_req, rd_addr, cls_start, ram_q,
    output mac_ready, rd_ack, rd_data, cls_busy, cls_done, cls_idx, cls_max,
           ram_addr, ram_data, ram_we
  );

  modport master (
    output mac_valid, mac_addr, mac_data, rd_req, rd_addr, cls_start, ram_q,
    input  mac_ready, rd_ack, rd_data, cls_busy, cls_done, cls_idx, cls_max,
           ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/ram_output_ctrl.sv
// Output-RAM controller: takes MAC result writes, serves host single-word
// reads and runs an argmax scan over all RAM entries. The RAM registers its
// address, so read data arrives one cycle after the address is driven.
// Arbitration happens only in IDLE (write > read > classify); anything else
// simply waits because requesters hold their request lines.
module ram_output_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_output_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    SCAN      = 2'd2,
    SCAN_LAST = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ZERO_A = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LAST_A = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ZERO_D = {DATA_WIDTH{1'b0}};

  state_t                state_r;
  state_t                next_state_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [DATA_WIDTH-1:0] run_max_r;
  logic [ADDR_WIDTH-1:0] run_idx_r;
  logic [ADDR_WIDTH-1:0] cls_idx_r;
  logic [DATA_WIDTH-1:0] cls_max_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_ack_r;
  logic                  cls_done_r;
  logic                  cls_busy_r;

  logic                  idle_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  cls_acc_s;
  logic                  take_s;
  logic [DATA_WIDTH-1:0] cand_max_s;
  logic [ADDR_WIDTH-1:0] cand_idx_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;

  // Request decode: which request (if any) wins the IDLE arbitration
  always_comb begin
    idle_s    = (state_r == IDLE);
    wr_acc_s  = idle_s & bus.mac_valid;
    // rd_ack still high means the host has not yet dropped the served request
    rd_acc_s  = idle_s & ~bus.mac_valid & bus.rd_req & ~rd_ack_r;
    cls_acc_s = idle_s & ~bus.mac_valid & ~bus.rd_req & bus.cls_start;
  end

  // Running-maximum candidate: entry 0 loads unconditionally, later entries
  // only replace on a strictly greater value so ties keep the lowest index
  always_comb begin
    take_s = ((state_r == SCAN) && (cnt_r == ONE_A)) || (bus.ram_q > run_max_r);
    if (take_s) begin
      cand_max_s = bus.ram_q;
      cand_idx_s = cnt_r - ONE_A;   // ram_q belongs to the previous address
    end else begin
      cand_max_s = run_max_r;
      cand_idx_s = run_idx_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (rd_acc_s) begin
          next_state_s = RD_WAIT;
        end else if (cls_acc_s) begin
          next_state_s = SCAN;
        end else begin
          next_state_s = IDLE;   // a write keeps the FSM in IDLE
        end
      end
      RD_WAIT: next_state_s = IDLE;
      SCAN: begin
        if (cnt_r == LAST_A) begin
          next_state_s = SCAN_LAST;
        end else begin
          next_state_s = SCAN;
        end
      end
      SCAN_LAST: next_state_s = IDLE;
      default:   next_state_s = IDLE;
    endcase
  end

  // Output decode: RAM address mux and write handshake
  always_comb begin
    ram_addr_s = ZERO_A;
    case (state_r)
      IDLE: begin
        if (bus.mac_valid) begin
          ram_addr_s = bus.mac_addr;
        end else if (rd_acc_s) begin
          ram_addr_s = bus.rd_addr;
        end else begin
          ram_addr_s = ZERO_A;     // covers classify accept (entry 0) and no request
        end
      end
      SCAN:    ram_addr_s = cnt_r;
      default: ram_addr_s = ZERO_A;
    endcase
  end

  assign bus.mac_ready = idle_s;
  assign bus.ram_we    = wr_acc_s;
  assign bus.ram_addr  = ram_addr_s;
  assign bus.ram_data  = bus.mac_data;
  assign bus.rd_ack    = rd_ack_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.cls_busy  = cls_busy_r;
  assign bus.cls_done  = cls_done_r;
  assign bus.cls_idx   = cls_idx_r;
  assign bus.cls_max   = cls_max_r;

  // Scan counter, running maximum and published classify result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= ZERO_A;
      run_max_r <= ZERO_D;
      run_idx_r <= ZERO_A;
      cls_idx_r <= ZERO_A;
      cls_max_r <= ZERO_D;
    end else begin
      case (state_r)
        IDLE: begin
          if (cls_acc_s) begin
            cnt_r <= ONE_A;
          end else begin
            cnt_r <= ZERO_A;
          end
        end
        SCAN: begin
          cnt_r     <= cnt_r + ONE_A;   // wraps to zero entering SCAN_LAST
          run_max_r <= cand_max_s;
          run_idx_r <= cand_idx_s;
        end
        SCAN_LAST: begin
          cnt_r     <= ZERO_A;
          cls_idx_r <= cand_idx_s;      // last entry is folded in here
          cls_max_r <= cand_max_s;
        end
        default: begin
          cnt_r <= ZERO_A;
        end
      endcase
    end
  end

  // Read data capture and the one-cycle ack/done pulses plus busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= ZERO_D;
      rd_ack_r   <= 1'b0;
      cls_done_r <= 1'b0;
      cls_busy_r <= 1'b0;
    end else begin
      if (state_r == RD_WAIT) begin
        rd_data_r <= bus.ram_q;
      end else begin
        rd_data_r <= rd_data_r;
      end
      rd_ack_r   <= (state_r == RD_WAIT);
      cls_done_r <= (state_r == SCAN_LAST);
      cls_busy_r <= (next_state_s == SCAN) || (next_state_s == SCAN_LAST);
    end
  end

endmodule
